// File: rtl/credit_tx_if.sv
// credit_tx_if: upstream valid/ready stream, downstream valid-only credit link and status
interface credit_tx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CREDIT_MAX = 4
);
    localparam int CNT_W = $clog2(CREDIT_MAX + 1);
    logic [DATA_WIDTH-1:0] bwd_data;
    logic                  bwd_valid;
    logic                  bwd_ready;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  fwd_valid;
    logic                  fwd_credit;
    logic [CNT_W-1:0]      credit_cnt;
    logic                  idle;
    logic                  err;
    modport master (
        input  bwd_data, bwd_valid, fwd_credit,
        output bwd_ready, fwd_data, fwd_valid, credit_cnt, idle, err
    );
    modport slave (
        output bwd_data, bwd_valid, fwd_credit,
        input  bwd_ready, fwd_data, fwd_valid, credit_cnt, idle, err
    );
endinterface

// File: rtl/credit_tx.sv
// credit_tx: credit-based link transmitter; ready decoded from the credit register only
module credit_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int CREDIT_MAX  = 4,
    parameter int INIT_CREDIT = 4
) (
    input logic        clk,
    input logic        rst,
    credit_tx_if.master link
);
    localparam int CNT_W = $clog2(CREDIT_MAX + 1);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(CREDIT_MAX);
    localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_CREDIT);
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  err_q;
    logic                  ready;
    logic                  hsk;
    logic                  ovf;
    assign ready = cnt != '0;
    assign hsk   = link.bwd_valid & ready;
    always_comb begin
        ovf      = link.fwd_credit & ~hsk & (cnt == MAX_C);
        cnt_next = ovf ? cnt : cnt + CNT_W'(link.fwd_credit) - CNT_W'(hsk);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= INIT_C;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            valid_q <= hsk;
            err_q   <= err_q | ovf;
        end
    end
    // payload is don't-care while valid is low, so it carries no reset
    always_ff @(posedge clk) begin
        if (hsk) data_q <= link.bwd_data;
    end
    assign link.bwd_ready  = ready;
    assign link.fwd_data   = data_q;
    assign link.fwd_valid  = valid_q;
    assign link.credit_cnt = cnt;
    assign link.idle       = (cnt == MAX_C) & ~valid_q;
    assign link.err        = err_q;
endmodule

// File: tb/tb_credit_tx.sv
// tb_credit_tx: directed plan plus random traffic checked against an integer credit model
module tb_credit_tx;
    localparam int DW = 8;
    localparam int CM = 4;
    localparam int IC = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    credit_tx_if #(.DATA_WIDTH(DW), .CREDIT_MAX(CM)) link ();
    credit_tx #(.DATA_WIDTH(DW), .CREDIT_MAX(CM), .INIT_CREDIT(IC)) dut (
        .clk (clk),
        .rst (rst),
        .link(link.master)
    );
    int n_vec = 0;
    int n_err = 0;
    int m_cnt = 0;
    bit m_known = 0;
    bit m_v = 0;
    bit m_err = 0;
    logic [DW-1:0] m_d = '0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // one clock: apply inputs, predict from credit arithmetic, check after the edge
    task automatic step(input bit r, input bit v, input bit c, input logic [DW-1:0] d);
        bit h;
        rst = r;
        link.bwd_valid = v;
        link.bwd_data = d;
        link.fwd_credit = c;
        #1;
        if (m_known) check("ready", link.bwd_ready, m_cnt > 0);
        h = v && m_cnt > 0;
        if (r) begin
            m_cnt = IC;
            m_v = 0;
            m_err = 0;
            m_known = 1;
        end else begin
            m_v = h;
            if (h) m_d = d;
            if (c && !h && m_cnt == CM) m_err = 1;
            else m_cnt = m_cnt + int'(c) - int'(h);
        end
        @(posedge clk);
        #1;
        check("fwd_valid", link.fwd_valid, m_v);
        if (m_v) check("fwd_data", link.fwd_data, m_d);
        check("credit_cnt", link.credit_cnt, m_cnt);
        check("idle", link.idle, m_cnt == CM && !m_v);
        check("err", link.err, m_err);
        check("no_wrap", link.credit_cnt <= CM, 1);
    endtask
    initial begin
        logic [DW-1:0] bd [5];
        int i;
        bd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        rst = 1'b1;
        link.bwd_valid = 1'b0;
        link.bwd_data = '0;
        link.fwd_credit = 1'b0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0);
        check("rst_ready", link.bwd_ready, 1);
        check("rst_cnt", link.credit_cnt, 4);
        check("rst_idle", link.idle, 1);
        // burst to empty: 0x55 must be held
        i = 0;
        repeat (5) begin
            bit h;
            h = m_cnt > 0;
            step(0, 1, 0, bd[i]);
            if (h) i++;
        end
        check("burst_cnt", link.credit_cnt, 0);
        check("burst_ready", link.bwd_ready, 0);
        check("burst_held", i, 4);
        // credit at empty
        step(0, 1, 1, bd[4]);
        check("credit_ready", link.bwd_ready, 1);
        check("credit_no_beat", link.fwd_valid, 0);
        step(0, 1, 0, bd[4]);
        check("beat55_data", link.fwd_data, 8'h55);
        check("beat55_valid", link.fwd_valid, 1);
        check("beat55_cnt", link.credit_cnt, 0);
        // simultaneous handshake and credit at cnt=2
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        repeat (6) begin
            step(0, 1, 1, DW'($urandom));
            check("sim_cnt", link.credit_cnt, 2);
            check("sim_valid", link.fwd_valid, 1);
        end
        // overflow at cnt=4
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("full_cnt", link.credit_cnt, 4);
        check("full_err", link.err, 0);
        step(0, 0, 1, 0);
        check("ovf_err", link.err, 1);
        check("ovf_cnt", link.credit_cnt, 4);
        step(0, 0, 0, 0);
        step(0, 1, 0, 8'hA5);
        check("ovf_sticky", link.err, 1);
        step(1, 0, 0, 0);
        check("ovf_clear", link.err, 0);
        // reset mid-burst with a beat in flight at cnt=1
        repeat (3) step(0, 1, 0, DW'($urandom));
        check("mid_cnt", link.credit_cnt, 1);
        check("mid_inflight", link.fwd_valid, 1);
        step(1, 1, 0, 8'h77);
        check("mid_valid", link.fwd_valid, 0);
        check("mid_cnt4", link.credit_cnt, 4);
        check("mid_ready", link.bwd_ready, 1);
        // random traffic with a well-behaved receiver plus rare overflow attempts
        repeat (3000) begin
            bit r, v, c;
            r = $urandom_range(0, 199) == 0;
            v = $urandom_range(0, 3) != 0;
            c = (m_cnt < CM && $urandom_range(0, 1) == 1) || $urandom_range(0, 99) == 0;
            step(r, v, c, DW'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
